ssd_scan_ctrl: RTL and testbench

- Parametrised multiplexed seven-segment scanner. Drives NUM_DIGITS common-anode digits from a packed hex value.
- Double-buffered: new values are applied only at a frame boundary, so the display never shows a torn value.
- Adds per-digit enable, decimal points, leading-zero blanking and anti-ghost dead time.
- Sits in the top level beside the display controller; replaces the hand-written anode and cathode scan logic.

---
 rtl/ssd_pkg.sv | 25 ++
 rtl/ssd_hex_decoder.sv | 12 +
 rtl/ssd_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - seven-segment scanner shared constants, hex table and width helper
package ssd_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low Ca..Cg patterns, entry n = hex digit n.
  localparam logic [15:0][6:0] HEX_SEG_TAB = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    return HEX_SEG_TAB[nibble];
  endfunction

  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// rtl/ssd_hex_decoder.sv - combinational nibble plus decimal point to active-low cathodes
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg_n
);

  assign seg_n = {hex2seg(nibble), ~dp};

endmodule

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - double-buffered multiplexed seven-segment scanner
// Optional digit blinking is built when SSD_BLINK_EN is defined.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 262144,
  parameter int DEAD_CYCLES  = 1024,
  parameter int BLINK_CYCLES = 50000000
) (
  input  logic                    ClkPort,
  input  logic                    Reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [7:0]              seg_n,
  output logic                    frame_done
);

  localparam int CNT_W = idx_width(DIGIT_CYCLES);
  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow_val, active_val;
  logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
  logic                    pending;

  logic                    slot_end, frame_end, visible;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   lz_hide, blink_hide;
  logic [7:0]              dec_seg, seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

`ifdef SSD_BLINK_EN
  localparam int BLK_W = idx_width(BLINK_CYCLES);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);

  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink_hide = blink_phase ? blink_mask : '0;
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign blink_hide = '0;
`endif

  // Walk down from the top digit; blanking stops at the first nonzero nibble or lit dp.
  always_comb begin
    zero_run = 1'b1;
    lz_hide  = '0;
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      zero_run = zero_run & (active_val[4*j +: 4] == 4'h0) & ~active_dp[j];
      if (j != 0) lz_hide[j] = lz_blank & zero_run;
    end
  end

  ssd_hex_decoder u_dec (
    .nibble (active_val[{idx, 2'b00} +: 4]),
    .dp     (active_dp[idx]),
    .seg_n  (dec_seg)
  );

  assign visible = digit_en[idx] & ~lz_hide[idx] & ~blink_hide[idx];

  always_comb begin
    an_next  = '1;
    seg_next = SEG_BLANK;
    if ((cnt >= CNT_DEAD) && visible) begin
      an_next[idx] = 1'b0;
      seg_next     = dec_seg;
    end
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      an_n       <= '1;
      seg_n      <= SEG_BLANK;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      frame_done <= frame_end;
      // A load coinciding with the boundary keeps pending so it lands a frame later.
      if (frame_end && pending) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
      end
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
      an_n  <= an_next;
      seg_n <= seg_next;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - randomized self-checking bench for ssd_scan_ctrl with a frame-level model
module tb_ssd_scan_ctrl;

  localparam int N     = 4;
  localparam int DC    = 4;
  localparam int DEAD  = 1;
  localparam int BLINK = 32;
  localparam int FRAME = N * DC;

  logic          ClkPort = 1'b0;
  logic          Reset_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    digit_en = 4'hF;
  logic          lz_blank = 1'b0;
  logic [3:0]    blink_mask = '0;
  logic [3:0]    an_n;
  logic [7:0]    seg_n;
  logic          frame_done;

  int tests = 0;
  int fails = 0;

  // Model state: edges since reset, shadow/active contents, pending flag.
  int          m_cyc = 0;
  logic [15:0] m_sh_v = '0, m_act_v = '0;
  logic [3:0]  m_sh_dp = '0, m_act_dp = '0;
  logic        m_pend = 1'b0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  ssd_scan_ctrl #(
    .NUM_DIGITS(N), .DIGIT_CYCLES(DC), .DEAD_CYCLES(DEAD), .BLINK_CYCLES(BLINK)
  ) dut (
    .ClkPort(ClkPort), .Reset_n(Reset_n), .load(load), .value(value),
    .dp_in(dp_in), .digit_en(digit_en), .lz_blank(lz_blank),
    .blink_mask(blink_mask), .an_n(an_n), .seg_n(seg_n), .frame_done(frame_done)
  );

  always #5 ClkPort = ~ClkPort;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_sh_v = '0; m_act_v = '0; m_sh_dp = '0; m_act_dp = '0; m_pend = 1'b0;
  endtask

  // One clock: predict what the edge registers, advance the model, then compare.
  task automatic cyc();
    int d, c;
    logic vis, hid;
    logic [3:0] ea;
    logic [7:0] es;
    logic ef;
    c = m_cyc % DC;
    d = (m_cyc % FRAME) / DC;
    hid = lz_blank && (d != 0);
    for (int j = d; j < N; j++)
      if (m_act_v[4*j +: 4] != 4'h0 || m_act_dp[j]) hid = 1'b0;
    vis = digit_en[d] && !hid;
`ifdef SSD_BLINK_EN
    if (((m_cyc / BLINK) % 2) == 1 && blink_mask[d]) vis = 1'b0;
`endif
    if (c >= DEAD && vis) begin
      ea = ~(4'b0001 << d);
      es = {seg_tab[m_act_v[4*d +: 4]], ~m_act_dp[d]};
    end else begin
      ea = 4'hF;
      es = 8'hFF;
    end
    ef = ((m_cyc % FRAME) == FRAME - 1);
    if (ef && m_pend) begin
      m_act_v = m_sh_v; m_act_dp = m_sh_dp; m_pend = 1'b0;
    end
    if (load) begin
      m_sh_v = value; m_sh_dp = dp_in; m_pend = 1'b1;
    end
    m_cyc++;
    @(posedge ClkPort);
    @(negedge ClkPort);
    chk("an_n", {4'h0, an_n}, {4'h0, ea});
    chk("seg_n", seg_n, es);
    chk("frame_done", {7'h0, frame_done}, {7'h0, ef});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic align(input int phase);
    while ((m_cyc % FRAME) != phase) cyc();
  endtask

  initial begin
    logic [15:0] rv;
    @(negedge ClkPort);
    @(negedge ClkPort);
    chk("reset_an_n", {4'h0, an_n}, 8'h0F);
    chk("reset_seg_n", seg_n, 8'hFF);
    chk("reset_frame_done", {7'h0, frame_done}, 8'h00);
    Reset_n = 1'b1;
    model_reset();

    do_load(16'h1234, 4'b0000);
    run(3 * FRAME);

    lz_blank = 1'b1;
    do_load(16'h0050, 4'b0000);
    run(3 * FRAME);
    do_load(16'h0000, 4'b0000);
    run(3 * FRAME);

    lz_blank = 1'b0;
    align(0);
    do_load(16'hAAAA, 4'b0000);
    run(3 * FRAME);
    align(FRAME - 1);
    do_load(16'h5A5A, 4'b1001);
    run(3 * FRAME);

    digit_en = 4'b1010;
    lz_blank = 1'b1;
    do_load(16'h0000, 4'b0001);
    run(3 * FRAME);

    for (int k = 0; k < 10; k++) begin
      rv = 16'($urandom);
      rv = rv >> (4 * $urandom_range(0, 3));
      digit_en = 4'($urandom);
      lz_blank = 1'($urandom);
      blink_mask = 4'($urandom);
      do_load(rv, 4'($urandom_range(0, 15)) & 4'($urandom));
      run($urandom_range(5, 40));
    end

    digit_en = 4'hF;
    lz_blank = 1'b0;
    blink_mask = 4'b0001;
    align(1);
    do_load(16'hBEEF, 4'b0100);
    run(3);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_reset_an_n", {4'h0, an_n}, 8'h0F);
    chk("async_reset_seg_n", seg_n, 8'hFF);
    chk("async_reset_frame_done", {7'h0, frame_done}, 8'h00);
    @(negedge ClkPort);
    Reset_n = 1'b1;
    model_reset();
    run(2 * FRAME);

    do_load(16'h8C3F, 4'b0010);
    run(5 * FRAME);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
